sobel3x3_frame_ctrl: RTL and testbench

SOBEL3X3_FRAME_CTRL -- requirements
Module: sobel3x3_frame_ctrl

---
 rtl/sobel3x3_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sobel3x3_frame_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel3x3_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel3x3_frame_ctrl
//
// Frame sequencer for a 3x3 Sobel engine fed by an AXI-Stream video input.
// It tracks line and column position, writes accepted pixels into the line
// buffer and emits one window beat per output pixel. The first line is only
// buffered (PRIME). Each later line produces the windows centred on the line
// above it (RUN). After the last line, W windows centred on the last row are
// produced with the input stalled (FLUSH). Top and bottom replicate flags tell
// the datapath which window rows to mirror. A border mask, delayed to match
// the datapath latency, marks outputs whose 3x3 window touches the image edge.
//
// Ports
//   s_axis_aclk       clock, all flops on rising edge
//   s_axis_areset     asynchronous active-high reset
//   cfg_enable        run enable (honoured only at frame boundaries)
//   cfg_edge_select   requested edge mode, latched at start of frame
//   s_axis_tvalid/tuser/tlast  pixel beat, start of frame, end of line
//   s_axis_tready     pixel accept
//   lb_wr_en          line-buffer write strobe (accepted pixel of a frame)
//   win_valid/win_tuser/win_tlast  window beat, first of frame, last of row
//   win_replicate     bit0 replicate top row, bit1 replicate bottom row
//   edge_selelct      edge mode latched for the current frame
//   mask_valid/border_mask  window-qualified mask, PIPE_LATENCY cycles late
//   frame_done        one-cycle pulse at the end of a complete frame
//   err_line_len      sticky: line ended at the wrong column
//   err_sof           sticky: start of frame arrived inside a frame
//   state             current FSM state
// -----------------------------------------------------------------------------
module sobel3x3_frame_ctrl #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIPE_LATENCY = 6
) (
    input  logic       s_axis_aclk,
    input  logic       s_axis_areset,
    input  logic       cfg_enable,
    input  logic       cfg_edge_select,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tuser,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic       lb_wr_en,
    output logic       win_valid,
    output logic       win_tuser,
    output logic       win_tlast,
    output logic [1:0] win_replicate,
    output logic       edge_selelct,
    output logic       mask_valid,
    output logic       border_mask,
    output logic       frame_done,
    output logic       err_line_len,
    output logic       err_sof,
    output logic [2:0] state
);

    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_PRIME    = 3'd2,
        S_RUN      = 3'd3,
        S_FLUSH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic              edge_reg, edge_next;
    logic              err_len_reg, err_len_next;
    logic              err_sof_reg, err_sof_next;

    logic              accept;
    logic              sof_beat;
    logic              pix_beat;
    logic              line_end;
    logic              len_err;
    logic [COL_W-1:0]  col_eff;
    logic [LINE_W-1:0] line_eff;
    logic [LINE_W-1:0] center_row;
    logic              ready_int;
    logic              win_int;
    logic              border_now;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    always_comb begin
        ready_int = (state_reg == S_WAIT_SOF) || (state_reg == S_PRIME) ||
                    (state_reg == S_RUN);
        accept    = s_axis_tvalid && ready_int;

        // A start-of-frame beat opens a frame from WAIT_SOF, or restarts one
        // from PRIME/RUN. A disabled block in WAIT_SOF just drains beats.
        sof_beat  = accept && s_axis_tuser &&
                    (((state_reg == S_WAIT_SOF) && cfg_enable) ||
                     (state_reg == S_PRIME) || (state_reg == S_RUN));
        pix_beat  = sof_beat ||
                    (accept && ((state_reg == S_PRIME) || (state_reg == S_RUN)));

        // A start-of-frame beat is always column 0 of line 0.
        col_eff   = sof_beat ? '0 : col_reg;
        line_eff  = sof_beat ? '0 : line_reg;

        // Either a tlast or the last column closes the line; disagreement
        // between the two is a line-length error, and the line still advances
        // so the stream resynchronises on its own tlast.
        line_end  = pix_beat && (s_axis_tlast || (col_eff == COL_LAST));
        len_err   = pix_beat && (s_axis_tlast != (col_eff == COL_LAST));
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        line_next    = line_reg;
        edge_next    = edge_reg;
        err_len_next = err_len_reg | len_err;
        err_sof_next = err_sof_reg;

        case (state_reg)
            S_IDLE: begin
                col_next  = '0;
                line_next = '0;
                if (cfg_enable) begin
                    state_next = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (!cfg_enable) begin
                    state_next = S_IDLE;
                end else if (sof_beat) begin
                    // New frame: error history starts fresh here.
                    err_len_next = len_err;
                    err_sof_next = 1'b0;
                    edge_next    = cfg_edge_select;
                end
            end
            S_PRIME, S_RUN: begin
                if (sof_beat) begin
                    err_sof_next = 1'b1;
                    edge_next    = cfg_edge_select;
                end
            end
            S_FLUSH: begin
                if (col_reg == COL_LAST) begin
                    col_next   = '0;
                    state_next = S_DONE;
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end
            S_DONE: begin
                col_next   = '0;
                line_next  = '0;
                state_next = cfg_enable ? S_WAIT_SOF : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Position tracking for every pixel that belongs to a frame.
        if (pix_beat) begin
            if (sof_beat) begin
                state_next = S_PRIME;
            end
            if (line_end) begin
                col_next = '0;
                if (line_eff == LINE_LAST) begin
                    line_next  = line_eff;
                    state_next = S_FLUSH;
                end else begin
                    line_next  = line_eff + 1'b1;
                    state_next = S_RUN;
                end
            end else begin
                col_next  = col_eff + 1'b1;
                line_next = line_eff;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_reg   <= S_IDLE;
            col_reg     <= '0;
            line_reg    <= '0;
            edge_reg    <= 1'b1;
            err_len_reg <= 1'b0;
            err_sof_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            line_reg    <= line_next;
            edge_reg    <= edge_next;
            err_len_reg <= err_len_next;
            err_sof_reg <= err_sof_next;
        end
    end

    // ------------------------------------------------------------------
    // Window outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Windows lag the input by one line; FLUSH supplies the last row.
        win_int    = (state_reg == S_FLUSH) ||
                     ((state_reg == S_RUN) && pix_beat && !sof_beat);
        center_row = (state_reg == S_FLUSH) ? LINE_LAST : (line_reg - 1'b1);
        border_now = win_int && ((center_row == '0) || (center_row == LINE_LAST) ||
                                 (col_reg == '0) || (col_reg == COL_LAST));
    end

    assign s_axis_tready    = ready_int;
    assign lb_wr_en         = pix_beat;
    assign win_valid        = win_int;
    assign win_tuser        = win_int && (center_row == '0) && (col_reg == '0);
    assign win_tlast        = win_int && (col_reg == COL_LAST);
    assign win_replicate[0] = win_int && (center_row == '0);
    assign win_replicate[1] = win_int && (center_row == LINE_LAST);
    assign edge_selelct     = edge_reg;
    assign frame_done       = (state_reg == S_DONE);
    assign err_line_len     = err_len_reg;
    assign err_sof          = err_sof_reg;
    assign state            = state_reg;

    // ------------------------------------------------------------------
    // Border mask delay line, aligned with the Sobel datapath output
    // ------------------------------------------------------------------
    generate
        if (PIPE_LATENCY == 0) begin : g_no_delay
            assign mask_valid  = win_int;
            assign border_mask = border_now;
        end else begin : g_delay
            logic [1:0] stage_reg [PIPE_LATENCY];

            always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
                if (s_axis_areset) begin
                    stage_reg[0] <= 2'b00;
                end else begin
                    stage_reg[0] <= {win_int, border_now};
                end
            end

            for (genvar gi = 1; gi < PIPE_LATENCY; gi++) begin : g_stage
                always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
                    if (s_axis_areset) begin
                        stage_reg[gi] <= 2'b00;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end

            assign mask_valid  = stage_reg[PIPE_LATENCY-1][1];
            assign border_mask = stage_reg[PIPE_LATENCY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_sobel3x3_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel3x3_frame_ctrl
//
// Self-checking bench for sobel3x3_frame_ctrl with a 4x3 image and a
// 6-cycle datapath latency. A table of frame scenarios (clean, early tlast,
// missing tlast, mid-frame SOF, back-to-back frames) is driven with random
// inter-beat gaps and random junk before SOF. Expected windows come from a
// position-level model: each accepted pixel gets a (row, col) from the stream
// rules, each pixel on row r>=1 yields the window centred on (r-1, col), and
// a finished frame adds the bottom-row windows. Hand-written sequences cover
// reset values, edge-mode latching and reset during FLUSH.
// -----------------------------------------------------------------------------
module tb_sobel3x3_frame_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_enable = 1'b0;
    logic       cfg_edge_select = 1'b1;
    logic       tvalid = 1'b0;
    logic       tuser = 1'b0;
    logic       tlast = 1'b0;

    logic       tready;
    logic       lb_wr_en;
    logic       win_valid;
    logic       win_tuser;
    logic       win_tlast;
    logic [1:0] win_replicate;
    logic       edge_selelct;
    logic       mask_valid;
    logic       border_mask;
    logic       frame_done;
    logic       err_line_len;
    logic       err_sof;
    logic [2:0] state;

    sobel3x3_frame_ctrl #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .PIPE_LATENCY(L)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_areset  (rst),
        .cfg_enable     (cfg_enable),
        .cfg_edge_select(cfg_edge_select),
        .s_axis_tvalid  (tvalid),
        .s_axis_tuser   (tuser),
        .s_axis_tlast   (tlast),
        .s_axis_tready  (tready),
        .lb_wr_en       (lb_wr_en),
        .win_valid      (win_valid),
        .win_tuser      (win_tuser),
        .win_tlast      (win_tlast),
        .win_replicate  (win_replicate),
        .edge_selelct   (edge_selelct),
        .mask_valid     (mask_valid),
        .border_mask    (border_mask),
        .frame_done     (frame_done),
        .err_line_len   (err_line_len),
        .err_sof        (err_sof),
        .state          (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: records every window beat, mask pulse and frame_done
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0] f;      // {tuser, tlast, replicate[1:0], tready}
        int         cyc;
    } wrec_t;
    typedef struct {
        logic b;
        int   cyc;
    } mrec_t;

    wrec_t wq[$];
    mrec_t mq[$];
    int    done_cnt = 0;

    always @(negedge clk) begin
        if (win_valid)
            wq.push_back('{f: {win_tuser, win_tlast, win_replicate, tready}, cyc: cyc});
        if (mask_valid)
            mq.push_back('{b: border_mask, cyc: cyc});
        if (frame_done)
            done_cnt <= done_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenario table
    // ------------------------------------------------------------------
    // kind: 0 clean frame, 1 early tlast at (line,col), 2 missing tlast on
    // line, 3 SOF at (line,col) followed by a full frame, 4 two clean frames
    typedef struct {
        int   kind;
        int   line;
        int   col;
        int   n_junk;
        int   exp_windows;
        int   exp_done;
        logic exp_len;
        logic exp_sof;
    } vec_t;

    vec_t       tbl[8];
    logic [1:0] beats[$];      // {tuser, tlast}
    logic [4:0] exp_f[$];
    logic       exp_b[$];

    task automatic append_clean();
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++)
                beats.push_back({(l == 0 && c == 0) ? 1'b1 : 1'b0, (c == W - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic build_beats(input vec_t v);
        beats.delete();
        for (int j = 0; j < v.n_junk; j++)
            beats.push_back({1'b0, 1'($urandom_range(0, 1))});
        for (int l = 0; l < H; l++) begin
            for (int c = 0; c < W; c++) begin
                logic u;
                logic t;
                u = (l == 0 && c == 0);
                t = (c == W - 1);
                if (v.kind == 3 && l == v.line && c == v.col) begin
                    append_clean();
                    return;
                end
                if (v.kind == 1 && l == v.line && c == v.col) begin
                    beats.push_back({u, 1'b1});
                    break;
                end
                if (v.kind == 2 && l == v.line && c == W - 1)
                    t = 1'b0;
                beats.push_back({u, t});
            end
        end
        if (v.kind == 4)
            append_clean();
    endtask

    task automatic push_window(input int r, input int c, input logic flush);
        logic [1:0] rep;
        rep = {(r == H - 1) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0};
        exp_f.push_back({(r == 0 && c == 0) ? 1'b1 : 1'b0, (c == W - 1) ? 1'b1 : 1'b0, rep, ~flush});
        exp_b.push_back((r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 1'b1 : 1'b0);
    endtask

    // Position-level reference: pixel positions from the stream rules,
    // windows centred one row above the incoming pixel, bottom row flushed.
    task automatic build_expect();
        int  row;
        int  col;
        bit  active;
        exp_f.delete();
        exp_b.delete();
        row = 0;
        col = 0;
        active = 0;
        foreach (beats[k]) begin
            if (beats[k][1]) begin
                active = 1;
                row = 0;
                col = 0;
            end
            if (active) begin
                if (row >= 1)
                    push_window(row - 1, col, 1'b0);
                if (beats[k][0] || col == W - 1) begin
                    col = 0;
                    row++;
                    if (row == H) begin
                        for (int c = 0; c < W; c++)
                            push_window(H - 1, c, 1'b1);
                        active = 0;
                        row = 0;
                    end
                end else begin
                    col++;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic send_beat(input logic u, input logic t);
        logic acc;
        int   guard;
        tvalid = 1'b1;
        tuser  = u;
        tlast  = t;
        acc    = 1'b0;
        guard  = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            guard++;
        end
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        chk("beat_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle_gap();
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int   wb;
        int   mb;
        int   db;
        int   nw;
        int   nm;
        logic eref;

        tbl[0] = '{0, 0, 0, 2, 12, 1, 1'b0, 1'b0};
        tbl[1] = '{1, 1, 2, 0, 11, 1, 1'b1, 1'b0};
        tbl[2] = '{2, 0, 3, 1, 12, 1, 1'b1, 1'b0};
        tbl[3] = '{3, 1, 2, 0, 14, 1, 1'b0, 1'b1};
        tbl[4] = '{4, 0, 0, 0, 24, 2, 1'b0, 1'b0};
        tbl[5] = '{1, 2, 0, 3,  9, 1, 1'b1, 1'b0};
        tbl[6] = '{0, 0, 0, 0, 12, 1, 1'b0, 1'b0};
        tbl[7] = '{2, 1, 3, 0, 12, 1, 1'b1, 1'b0};

        // Reset values
        #1 rst = 1'b1;
        cfg_enable = 1'b1;
        wait_cycles(2);
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_win",    {31'd0, win_valid}, 32'd0);
        chk("rst_lbwr",   {31'd0, lb_wr_en}, 32'd0);
        chk("rst_edge",   {31'd0, edge_selelct}, 32'd1);
        chk("rst_mask",   {30'd0, mask_valid, border_mask}, 32'd0);
        chk("rst_flags",  {29'd0, frame_done, err_line_len, err_sof}, 32'd0);
        rst = 1'b0;

        // Table-driven frames with random gaps
        for (int t = 0; t < 8; t++) begin
            do_reset();
            cfg_edge_select = 1'($urandom_range(0, 1));
            eref = cfg_edge_select;
            cfg_enable = 1'b1;
            wb = wq.size();
            mb = mq.size();
            db = done_cnt;
            build_beats(tbl[t]);
            build_expect();
            foreach (beats[k]) begin
                idle_gap();
                send_beat(beats[k][1], beats[k][0]);
            end
            wait_cycles(W + L + 8);

            nw = wq.size() - wb;
            nm = mq.size() - mb;
            chk($sformatf("t%0d_windows", t), nw, tbl[t].exp_windows);
            chk($sformatf("t%0d_done", t), done_cnt - db, tbl[t].exp_done);
            chk($sformatf("t%0d_err_len", t), {31'd0, err_line_len}, {31'd0, tbl[t].exp_len});
            chk($sformatf("t%0d_err_sof", t), {31'd0, err_sof}, {31'd0, tbl[t].exp_sof});
            chk($sformatf("t%0d_edge", t), {31'd0, edge_selelct}, {31'd0, eref});
            chk($sformatf("t%0d_masks", t), nm, tbl[t].exp_windows);
            for (int i = 0; i < nw && i < exp_f.size(); i++) begin
                chk($sformatf("t%0d_win%0d_flags", t, i), {27'd0, wq[wb + i].f}, {27'd0, exp_f[i]});
                if (i < nm) begin
                    chk($sformatf("t%0d_mask%0d_delay", t, i), mq[mb + i].cyc - wq[wb + i].cyc, L);
                    chk($sformatf("t%0d_mask%0d_border", t, i), {31'd0, mq[mb + i].b}, {31'd0, exp_b[i]});
                end
            end

            // A fresh SOF from WAIT_SOF clears the sticky errors
            chk($sformatf("t%0d_wait_sof", t), {29'd0, state}, 32'd1);
            send_beat(1'b1, 1'b0);
            chk($sformatf("t%0d_err_clr", t), {30'd0, err_line_len, err_sof}, 32'd0);
            chk($sformatf("t%0d_prime", t), {29'd0, state}, 32'd2);
            $display("vector %0d kind=%0d beats=%0d windows=%0d done=%0d len=%0b sof=%0b",
                     t, tbl[t].kind, beats.size(), nw, tbl[t].exp_done,
                     tbl[t].exp_len, tbl[t].exp_sof);
        end

        // Edge mode latches only at start of frame
        do_reset();
        cfg_enable = 1'b1;
        cfg_edge_select = 1'b0;
        send_beat(1'b1, 1'b0);
        chk("edge_at_sof", {31'd0, edge_selelct}, 32'd0);
        cfg_edge_select = 1'b1;
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++)
                if (!(l == 0 && c == 0))
                    send_beat(1'b0, (c == W - 1) ? 1'b1 : 1'b0);
        chk("edge_midframe", {31'd0, edge_selelct}, 32'd0);
        wait_cycles(W + 4);
        chk("edge_before_sof", {31'd0, edge_selelct}, 32'd0);
        send_beat(1'b1, 1'b0);
        chk("edge_next_sof", {31'd0, edge_selelct}, 32'd1);
        $display("edge latch sequence done");

        // Reset during FLUSH drops the frame
        do_reset();
        cfg_enable = 1'b1;
        db = done_cnt;
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++)
                send_beat((l == 0 && c == 0) ? 1'b1 : 1'b0, (c == W - 1) ? 1'b1 : 1'b0);
        chk("flush_state", {29'd0, state}, 32'd4);
        chk("flush_tready", {31'd0, tready}, 32'd0);
        chk("flush_win", {31'd0, win_valid}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_win", {28'd0, win_valid, win_tuser, win_tlast, lb_wr_en}, 32'd0);
        chk("arst_rep", {30'd0, win_replicate}, 32'd0);
        chk("arst_mask", {30'd0, mask_valid, border_mask}, 32'd0);
        chk("arst_done", {31'd0, frame_done}, 32'd0);
        chk("arst_edge", {31'd0, edge_selelct}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(W + L + 4);
        chk("arst_no_done", done_cnt - db, 0);
        chk("arst_wait_sof", {29'd0, state}, 32'd1);
        $display("reset during flush sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
